// File: rtl/debug_hart_irq_ctrl_if.sv
// Debug-module to hart-cluster request/status bundle.
// master = debug module side, slave = conditioner side.
interface debug_hart_irq_ctrl_if #(
    parameter int NR_HARTS = 1
);
    logic [NR_HARTS-1:0] dm_debug_req;
    logic                dm_ndmreset;
    logic [NR_HARTS-1:0] hart_en_mask;
    logic [NR_HARTS-1:0] debug_req_irq;
    logic                ndmreset;
    logic [NR_HARTS-1:0] req_pending;
    logic [15:0]         irq_count;

    modport master (
        output dm_debug_req,
        output dm_ndmreset,
        output hart_en_mask,
        input  debug_req_irq,
        input  ndmreset,
        input  req_pending,
        input  irq_count
    );

    modport slave (
        input  dm_debug_req,
        input  dm_ndmreset,
        input  hart_en_mask,
        output debug_req_irq,
        output ndmreset,
        output req_pending,
        output irq_count
    );
endinterface

// File: rtl/debug_hart_irq_ctrl.sv
// Per-hart debug request edge-to-pulse conditioner with
// re-arm gap, pending capture, ndmreset stretch and pulse count.
module debug_hart_irq_ctrl #(
    parameter int NR_HARTS            = 1,
    parameter int IRQ_PULSE_CYCLES    = 4,
    parameter int REARM_GAP           = 2,
    parameter int NDMRESET_MIN_CYCLES = 16
) (
    input logic             aclk,
    input logic             areset,
    debug_hart_irq_ctrl_if.slave bus
);

    localparam int MAXC = (IRQ_PULSE_CYCLES > REARM_GAP) ?
                          IRQ_PULSE_CYCLES : REARM_GAP;
    localparam int CW = $clog2(MAXC + 1);
    localparam int RW = $clog2(NDMRESET_MIN_CYCLES + 1);
    localparam logic [CW-1:0] P_LOAD = CW'(IRQ_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(REARM_GAP - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(NDMRESET_MIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_e;

    state_e              state_q [NR_HARTS];
    state_e              state_d [NR_HARTS];
    logic [CW-1:0]       cnt_q   [NR_HARTS];
    logic [CW-1:0]       cnt_d   [NR_HARTS];
    logic [NR_HARTS-1:0] pend_q, pend_d;
    logic [NR_HARTS-1:0] prev_q, prev_d;
    logic [NR_HARTS-1:0] enter;
    logic [NR_HARTS-1:0] cap;
    logic                ndm_prev_q, ndm_prev_d;
    logic                ndmreset_q, ndmreset_d;
    logic [RW-1:0]       rcnt_q, rcnt_d;
    logic [15:0]         count_q, count_d;
    logic                ndm_rise;
    logic                hold;
    logic [6:0]          n_enter;
    logic [16:0]         sum;
    logic [NR_HARTS-1:0] irq_vec;

    always_comb begin
        prev_d     = bus.dm_debug_req;
        ndm_prev_d = bus.dm_ndmreset;
        ndm_rise   = bus.dm_ndmreset & ~ndm_prev_q;
        // A reset edge beats a debug edge arriving in the same cycle.
        hold       = ndm_rise | ndmreset_q;
        cap        = bus.dm_debug_req & ~prev_q & bus.hart_en_mask;
        pend_d     = pend_q;
        enter      = '0;
        n_enter    = '0;
        for (int i = 0; i < NR_HARTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (hold) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                pend_d[i]  = 1'b0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        if (cap[i]) begin
                            state_d[i] = PULSE;
                            cnt_d[i]   = P_LOAD;
                            enter[i]   = 1'b1;
                        end
                    end
                    PULSE: begin
                        if (cap[i]) pend_d[i] = 1'b1;
                        if (cnt_q[i] == '0) begin
                            state_d[i] = GAP;
                            cnt_d[i]   = G_LOAD;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                            if (cap[i]) pend_d[i] = 1'b1;
                        end else if (pend_q[i] | cap[i]) begin
                            // Pending launches; a fresh edge re-captures.
                            state_d[i] = PULSE;
                            cnt_d[i]   = P_LOAD;
                            enter[i]   = 1'b1;
                            pend_d[i]  = pend_q[i] & cap[i];
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            n_enter = n_enter + 7'(enter[i]);
        end
        sum     = {1'b0, count_q} + 17'(n_enter);
        count_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_comb begin
        ndmreset_d = ndmreset_q;
        rcnt_d     = rcnt_q;
        if (ndm_rise) begin
            ndmreset_d = 1'b1;
            rcnt_d     = R_LOAD;
        end else if (ndmreset_q) begin
            if (rcnt_q != '0) begin
                rcnt_d = rcnt_q - RW'(1);
            end else if (!bus.dm_ndmreset) begin
                ndmreset_d = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            prev_q     <= bus.dm_debug_req;
            ndm_prev_q <= bus.dm_ndmreset;
            pend_q     <= '0;
            ndmreset_q <= 1'b0;
            rcnt_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < NR_HARTS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q     <= prev_d;
            ndm_prev_q <= ndm_prev_d;
            pend_q     <= pend_d;
            ndmreset_q <= ndmreset_d;
            rcnt_q     <= rcnt_d;
            count_q    <= count_d;
            for (int i = 0; i < NR_HARTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR_HARTS; i++) begin
            irq_vec[i] = (state_q[i] == PULSE);
        end
    end

    assign bus.debug_req_irq = irq_vec;
    assign bus.req_pending   = pend_q;
    assign bus.ndmreset      = ndmreset_q;
    assign bus.irq_count     = count_q;

endmodule
